// File: rtl/slc3_isdu.sv
// SLC-3 instruction sequence/decode unit: Moore FSM driving datapath loads,
// bus gates, mux selects and memory strobes through fetch/decode/execute.
module slc3_isdu #(
  parameter int MEM_WAIT = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_run,
  input  logic       i_continue,
  input  logic [3:0] i_opcode,
  input  logic       i_ir_5,
  input  logic       i_ir_11,
  input  logic       i_ben,
  output logic       o_ld_mar,
  output logic       o_ld_mdr,
  output logic       o_ld_ir,
  output logic       o_ld_ben,
  output logic       o_ld_cc,
  output logic       o_ld_reg,
  output logic       o_ld_pc,
  output logic       o_ld_led,
  output logic       o_gate_pc,
  output logic       o_gate_mdr,
  output logic       o_gate_alu,
  output logic       o_gate_marmux,
  output logic [1:0] o_pcmux,
  output logic       o_drmux,
  output logic       o_sr1mux,
  output logic       o_sr2mux,
  output logic       o_addr1mux,
  output logic [1:0] o_addr2mux,
  output logic [1:0] o_aluk,
  output logic       o_mem_oe,
  output logic       o_mem_we
);

  // state  | meaning
  // HALTED | idle until Run rises
  // F1     | MAR <- PC, PC <- PC+1
  // F2     | memory read wait, MDR loaded on last cycle
  // F3     | IR <- MDR
  // DEC    | BEN load, opcode dispatch
  // ALU    | ADD/AND/NOT writeback
  // BR0/1  | branch test / PC <- PC+off9
  // JMP    | PC <- SR1
  // J1/J2  | R7 <- PC, then PC <- target
  // L1-L3  | LDR address, read wait, writeback
  // S1-S3  | STR address, MDR <- SR, write wait
  // P0/P1  | LED load, hold until Continue rises
  typedef enum logic [4:0] {
    S_HALTED, S_F1, S_F2, S_F3, S_DEC, S_ALU, S_BR0, S_BR1, S_JMP,
    S_J1, S_J2, S_L1, S_L2, S_L3, S_S1, S_S2, S_S3, S_P0, S_P1
  } state_t;

  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_wait;
  logic            r_run_prev, r_cont_prev;
  logic            w_run_rise, w_cont_rise, w_wait_last, w_in_wait;

  assign w_run_rise  = i_run & ~r_run_prev;
  assign w_cont_rise = i_continue & ~r_cont_prev;
  assign w_wait_last = (r_wait == CW'(MEM_WAIT - 1));
  assign w_in_wait   = (r_state == S_F2) || (r_state == S_L2) || (r_state == S_S3);

  // Wait states never follow each other, so leaving one always passes through a clear.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_HALTED;
      r_wait      <= '0;
      r_run_prev  <= 1'b1;
      r_cont_prev <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_wait      <= w_in_wait ? r_wait + CW'(1) : '0;
      r_run_prev  <= i_run;
      r_cont_prev <= i_continue;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_HALTED: if (w_run_rise) w_state_next = S_F1;
      S_F1:     w_state_next = S_F2;
      S_F2:     if (w_wait_last) w_state_next = S_F3;
      S_F3:     w_state_next = S_DEC;
      S_DEC: begin
        case (i_opcode)
          4'b0001, 4'b0101, 4'b1001: w_state_next = S_ALU;
          4'b0000: w_state_next = S_BR0;
          4'b1100: w_state_next = S_JMP;
          4'b0100: w_state_next = S_J1;
          4'b0110: w_state_next = S_L1;
          4'b0111: w_state_next = S_S1;
          4'b1101: w_state_next = S_P0;
          default: w_state_next = S_F1;
        endcase
      end
      S_BR0:    w_state_next = i_ben ? S_BR1 : S_F1;
      S_J1:     w_state_next = S_J2;
      S_L1:     w_state_next = S_L2;
      S_L2:     if (w_wait_last) w_state_next = S_L3;
      S_S1:     w_state_next = S_S2;
      S_S2:     w_state_next = S_S3;
      S_S3:     if (w_wait_last) w_state_next = S_F1;
      S_P0:     w_state_next = S_P1;
      S_P1:     if (w_cont_rise) w_state_next = S_F1;
      default:  w_state_next = S_F1;
    endcase
  end

  always_comb begin
    o_ld_mar = 1'b0; o_ld_mdr = 1'b0; o_ld_ir = 1'b0; o_ld_ben = 1'b0;
    o_ld_cc = 1'b0; o_ld_reg = 1'b0; o_ld_pc = 1'b0; o_ld_led = 1'b0;
    o_gate_pc = 1'b0; o_gate_mdr = 1'b0; o_gate_alu = 1'b0; o_gate_marmux = 1'b0;
    o_pcmux = 2'b00; o_drmux = 1'b0; o_sr1mux = 1'b0; o_sr2mux = 1'b0;
    o_addr1mux = 1'b0; o_addr2mux = 2'b00; o_aluk = 2'b00;
    o_mem_oe = 1'b0; o_mem_we = 1'b0;
    case (r_state)
      S_F1: begin
        o_gate_pc = 1'b1; o_ld_mar = 1'b1; o_ld_pc = 1'b1;
      end
      S_F2, S_L2: begin
        o_mem_oe = 1'b1;
        o_ld_mdr = w_wait_last;
      end
      S_F3: begin
        o_gate_mdr = 1'b1; o_ld_ir = 1'b1;
      end
      S_DEC: o_ld_ben = 1'b1;
      S_ALU: begin
        o_sr1mux = 1'b1; o_sr2mux = i_ir_5;
        case (i_opcode)
          4'b0101: o_aluk = 2'b01;
          4'b1001: o_aluk = 2'b10;
          default: o_aluk = 2'b00;
        endcase
        o_gate_alu = 1'b1; o_ld_reg = 1'b1; o_ld_cc = 1'b1;
      end
      S_BR1: begin
        o_addr2mux = 2'b10; o_pcmux = 2'b10; o_ld_pc = 1'b1;
      end
      S_JMP: begin
        o_addr1mux = 1'b1; o_sr1mux = 1'b1; o_pcmux = 2'b10; o_ld_pc = 1'b1;
      end
      S_J1: begin
        o_gate_pc = 1'b1; o_drmux = 1'b1; o_ld_reg = 1'b1;
      end
      S_J2: begin
        if (i_ir_11) begin
          o_addr2mux = 2'b11;
        end else begin
          o_addr1mux = 1'b1; o_sr1mux = 1'b1;
        end
        o_pcmux = 2'b10; o_ld_pc = 1'b1;
      end
      S_L1, S_S1: begin
        o_addr1mux = 1'b1; o_sr1mux = 1'b1; o_addr2mux = 2'b01;
        o_gate_marmux = 1'b1; o_ld_mar = 1'b1;
      end
      S_L3: begin
        o_gate_mdr = 1'b1; o_ld_reg = 1'b1; o_ld_cc = 1'b1;
      end
      S_S2: begin
        o_aluk = 2'b11; o_gate_alu = 1'b1; o_ld_mdr = 1'b1;
      end
      S_S3: o_mem_we = 1'b1;
      S_P0: o_ld_led = 1'b1;
      default: ;
    endcase
  end

endmodule
